// File: rtl/matriz_scan_decoder.sv
// Receive side of the 5x7 matrix scan: rebuilds the frame from L/C lines.
// Publishes frame with valid strobe, lock flag, error pulse and counter.
module matriz_scan_decoder #(
  parameter int unsigned STABLE_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 65535,
  parameter bit          INPUT_ACTIVE_LOW = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  L,
  input  logic [6:0]  C,
  output logic [34:0] frame,
  output logic        frame_valid,
  output logic        locked,
  output logic        error,
  output logic [7:0]  frame_cnt
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] SONE = SW'(1);
  localparam logic [IW-1:0] TMAX = IW'(TIMEOUT_CYCLES);

  typedef enum logic {
    HUNT,
    CAPTURE
  } state_t;

  state_t        state;
  logic [11:0]   sync1;
  logic [11:0]   sync2;
  logic [11:0]   prev;
  logic [11:0]   sample;
  logic [SW-1:0] stab_cnt;
  logic [SW-1:0] stab_nxt;
  logic          slot_done;
  logic [IW-1:0] idle;
  logic [IW-1:0] idle_inc;
  logic [2:0]    exp_row;
  logic [34:0]   shadow;
  logic          pend;
  logic          err_hold;

  logic [4:0]    lpart;
  logic [6:0]    cpart;
  logic          lchg;
  logic          chg;
  logic          accept;
  logic [2:0]    row;
  logic          onehot;
  logic          timeout;
  logic          err_evt;
  logic          err_out;

  function automatic logic [34:0] put_row(
    input logic [34:0] f,
    input logic [2:0]  r,
    input logic [6:0]  v
  );
    logic [34:0] o;
    o = f;
    case (r)
      3'd0:    o[6:0]   = v;
      3'd1:    o[13:7]  = v;
      3'd2:    o[20:14] = v;
      3'd3:    o[27:21] = v;
      3'd4:    o[34:28] = v;
      default: o = f;
    endcase
    return o;
  endfunction

  always_comb begin
    sample = INPUT_ACTIVE_LOW ? ~sync2 : sync2;
    lpart  = sample[11:7];
    cpart  = sample[6:0];
    lchg   = lpart != prev[11:7];
    chg    = sample != prev;
  end

  always_comb begin
    stab_nxt = stab_cnt;
    if (chg)
      stab_nxt = SONE;
    else if (stab_cnt != SMAX)
      stab_nxt = stab_cnt + 1'b1;
  end

  // slot_done only blocks while L is unchanged, so a new slot is never masked
  always_comb begin
    accept = (stab_nxt == SMAX)
           && (lpart != 5'd0)
           && !(slot_done && !lchg);
  end

  always_comb begin
    row    = 3'd0;
    onehot = 1'b1;
    case (lpart)
      5'b00001: row = 3'd0;
      5'b00010: row = 3'd1;
      5'b00100: row = 3'd2;
      5'b01000: row = 3'd3;
      5'b10000: row = 3'd4;
      default:  onehot = 1'b0;
    endcase
  end

  always_comb begin
    idle_inc = idle + 1'b1;
    timeout  = (state == CAPTURE) && (idle_inc == TMAX);
    err_evt  = 1'b0;
    if (accept)
      err_evt = !onehot
             || ((state == CAPTURE) && (row != exp_row));
    else
      err_evt = timeout;
    err_out = err_evt | err_hold;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      stab_cnt  <= '0;
      slot_done <= 1'b0;
    end else begin
      sync1     <= {L, C};
      sync2     <= sync1;
      prev      <= sample;
      stab_cnt  <= stab_nxt;
      slot_done <= accept | (slot_done & ~lchg);
    end
  end

  // an error landing on the commit cycle is delayed one clock
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= HUNT;
      exp_row     <= 3'd0;
      shadow      <= '0;
      idle        <= '0;
      pend        <= 1'b0;
      err_hold    <= 1'b0;
      frame       <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      error       <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      pend        <= 1'b0;
      frame_valid <= pend;
      err_hold    <= err_out & pend;
      error       <= err_out & ~pend;

      if (accept || timeout || state == HUNT)
        idle <= '0;
      else
        idle <= idle_inc;

      if (pend) begin
        frame     <= shadow;
        frame_cnt <= frame_cnt + 8'd1;
        locked    <= 1'b1;
      end else if (err_out) begin
        locked    <= 1'b0;
      end

      if (accept) begin
        if (!onehot) begin
          state  <= HUNT;
          shadow <= '0;
        end else if (state == HUNT) begin
          if (row == 3'd0) begin
            shadow  <= put_row(shadow, 3'd0, cpart);
            exp_row <= 3'd1;
            state   <= CAPTURE;
          end
        end else if (row == exp_row) begin
          shadow <= put_row(shadow, row, cpart);
          if (exp_row == 3'd4) begin
            exp_row <= 3'd0;
            pend    <= 1'b1;
          end else begin
            exp_row <= exp_row + 3'd1;
          end
        end else if (row == 3'd0) begin
          shadow  <= put_row(shadow, 3'd0, cpart);
          exp_row <= 3'd1;
        end else begin
          state <= HUNT;
        end
      end else if (timeout) begin
        state <= HUNT;
      end
    end
  end

endmodule

// File: tb/tb_matriz_scan_decoder.sv
// Bench for matriz_scan_decoder: scripted scans with a frame scoreboard.
// Frames are queued as scans are driven and popped on frame_valid.
module tb_matriz_scan_decoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [4:0]  L = 5'd0;
  logic [6:0]  C = 7'd0;
  logic [34:0] frame;
  logic        frame_valid;
  logic        locked;
  logic        error;
  logic [7:0]  frame_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int err_seen = 0;
  int last_err_cyc = -1;
  int last_fv_cyc = -1;
  logic [7:0]  exp_cnt = 8'd0;
  logic [34:0] exp_f;
  logic [34:0] q[$];

  matriz_scan_decoder #(
    .STABLE_CYCLES(4),
    .TIMEOUT_CYCLES(20),
    .INPUT_ACTIVE_LOW(1'b0)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .L(L),
    .C(C),
    .frame(frame),
    .frame_valid(frame_valid),
    .locked(locked),
    .error(error),
    .frame_cnt(frame_cnt)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  always @(negedge CLK) begin
    if (!RST) begin
      if (error) begin
        err_seen = err_seen + 1;
        last_err_cyc = cyc;
      end
      if (frame_valid) begin
        last_fv_cyc = cyc;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame got=%h", frame);
        end else begin
          exp_f = q.pop_front();
          if (frame !== exp_f) begin
            errors++;
            $display("FAIL frame got=%h want=%h", frame, exp_f);
          end
        end
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (frame_cnt !== exp_cnt) begin
          errors++;
          $display("FAIL frame_cnt got=%0d want=%0d",
                   frame_cnt, exp_cnt);
        end
        checks++;
        if (error !== 1'b0) begin
          errors++;
          $display("FAIL err_with_valid got=%b want=0", error);
        end
      end
    end
  end

  task automatic slot(input logic [4:0] l, input logic [6:0] c,
                      input int n);
    L = l;
    C = c;
    repeat (n) @(negedge CLK);
  endtask

  task automatic scan(input logic [34:0] f, input int n,
                      input int gap, output int t5);
    t5 = 0;
    for (int r = 0; r < 5; r++) begin
      if (r == 4) begin
        q.push_back(f);
        t5 = cyc;
      end
      slot(5'(1 << r), f[7*r +: 7], n);
      if (gap > 0) slot(5'd0, 7'd0, gap);
    end
  endtask

  task automatic do_reset;
    @(negedge CLK);
    L = 5'd0;
    C = 7'd0;
    RST = 1'b1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_frames got=%0d want=0", q.size());
    end
    q.delete();
    exp_cnt = 8'd0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks += 5;
    if (frame !== 35'd0) begin
      errors++; $display("FAIL rst_frame got=%h want=0", frame);
    end
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL rst_fv got=%b want=0", frame_valid);
    end
    if (locked !== 1'b0) begin
      errors++; $display("FAIL rst_locked got=%b want=0", locked);
    end
    if (error !== 1'b0) begin
      errors++; $display("FAIL rst_error got=%b want=0", error);
    end
    if (frame_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_cnt got=%0d want=0", frame_cnt);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (8) @(negedge CLK);
    checks += 2;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL idle_locked got=%b want=0", locked);
    end
    if (err_seen !== 0) begin
      errors++; $display("FAIL idle_errors got=%0d want=0", err_seen);
    end
  endtask

  task automatic test_clean_frame;
    logic [34:0] f;
    int t5;
    int e0;
    do_reset;
    e0 = err_seen;
    f = {7'h7F, 7'h08, 7'h14, 7'h22, 7'h41};
    scan(f, 10, 0, t5);
    repeat (2) @(negedge CLK);
    checks += 5;
    if (last_fv_cyc != t5 + 7) begin
      errors++;
      $display("FAIL latency got=%0d want=%0d",
               last_fv_cyc - t5 - 1, 6);
    end
    if (frame !== f) begin
      errors++; $display("FAIL clean_frame got=%h want=%h", frame, f);
    end
    if (locked !== 1'b1) begin
      errors++; $display("FAIL clean_locked got=%b want=1", locked);
    end
    if (frame_cnt !== 8'd1) begin
      errors++; $display("FAIL clean_cnt got=%0d want=1", frame_cnt);
    end
    if (err_seen != e0) begin
      errors++; $display("FAIL clean_err got=%0d want=0", err_seen - e0);
    end
  endtask

  task automatic test_glitch;
    logic [34:0] f;
    int e0;
    do_reset;
    e0 = err_seen;
    f = {7'h33, 7'h4C, 7'h1E, 7'h61, 7'h55};
    slot(5'b00001, 7'h2A, 1);
    slot(5'b00001, 7'h15, 1);
    slot(5'b00001, 7'h55, 8);
    for (int r = 1; r < 5; r++) begin
      if (r == 4) q.push_back(f);
      slot(5'(1 << r), f[7*r +: 7], 10);
    end
    repeat (2) @(negedge CLK);
    checks += 2;
    if (frame !== f) begin
      errors++; $display("FAIL glitch_frame got=%h want=%h", frame, f);
    end
    if (err_seen != e0) begin
      errors++; $display("FAIL glitch_err got=%0d want=0", err_seen - e0);
    end
  endtask

  task automatic test_short_slot;
    logic [34:0] f;
    int t5;
    int e0;
    do_reset;
    e0 = err_seen;
    f = {7'h01, 7'h02, 7'h04, 7'h08, 7'h10};
    slot(5'b00001, 7'h11, 3);
    for (int r = 1; r < 5; r++) slot(5'(1 << r), 7'h22, 10);
    slot(5'd0, 7'd0, 4);
    checks += 3;
    if (err_seen != e0) begin
      errors++; $display("FAIL short_err got=%0d want=0", err_seen - e0);
    end
    if (locked !== 1'b0) begin
      errors++; $display("FAIL short_locked got=%b want=0", locked);
    end
    if (frame_cnt !== 8'd0) begin
      errors++; $display("FAIL short_cnt got=%0d want=0", frame_cnt);
    end
    scan(f, 10, 0, t5);
    repeat (2) @(negedge CLK);
    checks++;
    if (frame_cnt !== 8'd1) begin
      errors++; $display("FAIL short_after got=%0d want=1", frame_cnt);
    end
  endtask

  task automatic test_skip_row;
    logic [34:0] f;
    int t5;
    int e0;
    do_reset;
    e0 = err_seen;
    f = {7'h3C, 7'h42, 7'h42, 7'h42, 7'h3C};
    slot(5'b00001, 7'h70, 10);
    slot(5'b00010, 7'h07, 10);
    slot(5'b01000, 7'h0F, 10);
    checks += 3;
    if (err_seen != e0 + 1) begin
      errors++;
      $display("FAIL skip_err got=%0d want=1", err_seen - e0);
    end
    if (locked !== 1'b0) begin
      errors++; $display("FAIL skip_locked got=%b want=0", locked);
    end
    if (frame_cnt !== 8'd0) begin
      errors++; $display("FAIL skip_cnt got=%0d want=0", frame_cnt);
    end
    scan(f, 10, 0, t5);
    repeat (2) @(negedge CLK);
    checks += 2;
    if (frame !== f) begin
      errors++; $display("FAIL skip_frame got=%h want=%h", frame, f);
    end
    if (locked !== 1'b1) begin
      errors++; $display("FAIL skip_relock got=%b want=1", locked);
    end
  endtask

  task automatic test_multi_blank;
    logic [34:0] f;
    logic [34:0] f2;
    int t5;
    int e0;
    do_reset;
    e0 = err_seen;
    f  = {7'h11, 7'h22, 7'h33, 7'h44, 7'h55};
    f2 = {7'h6A, 7'h15, 7'h2B, 7'h54, 7'h01};
    scan(f, 10, 2, t5);
    checks += 2;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL blank_locked got=%b want=1", locked);
    end
    if (err_seen != e0) begin
      errors++; $display("FAIL blank_err got=%0d want=0", err_seen - e0);
    end
    slot(5'b00001, 7'h01, 10);
    slot(5'b00010, 7'h02, 10);
    slot(5'b00011, 7'h7F, 10);
    checks += 3;
    if (err_seen != e0 + 1) begin
      errors++;
      $display("FAIL multi_err got=%0d want=1", err_seen - e0);
    end
    if (locked !== 1'b0) begin
      errors++; $display("FAIL multi_locked got=%b want=0", locked);
    end
    if (frame !== f) begin
      errors++; $display("FAIL multi_frame got=%h want=%h", frame, f);
    end
    slot(5'd0, 7'd0, 3);
    scan(f2, 10, 0, t5);
    repeat (2) @(negedge CLK);
    checks += 2;
    if (frame_cnt !== 8'd2) begin
      errors++; $display("FAIL multi_cnt got=%0d want=2", frame_cnt);
    end
    if (err_seen != e0 + 1) begin
      errors++;
      $display("FAIL multi_err2 got=%0d want=1", err_seen - e0);
    end
  endtask

  task automatic test_timeout;
    logic [34:0] f;
    int t5;
    int e0;
    do_reset;
    e0 = err_seen;
    f = {7'h7E, 7'h81 & 7'h7F, 7'h5A, 7'h24, 7'h18};
    scan(f, 10, 0, t5);
    slot(5'd0, 7'd0, 1);
    for (int i = 0; i < 40 && err_seen == e0; i++) @(negedge CLK);
    repeat (5) @(negedge CLK);
    checks += 5;
    if (err_seen != e0 + 1) begin
      errors++;
      $display("FAIL timeout_err got=%0d want=1", err_seen - e0);
    end
    if (last_err_cyc != t5 + 26) begin
      errors++;
      $display("FAIL timeout_at got=%0d want=%0d",
               last_err_cyc, t5 + 26);
    end
    if (locked !== 1'b0) begin
      errors++; $display("FAIL timeout_locked got=%b want=0", locked);
    end
    if (frame !== f) begin
      errors++; $display("FAIL timeout_frame got=%h want=%h", frame, f);
    end
    if (frame_cnt !== 8'd1) begin
      errors++; $display("FAIL timeout_cnt got=%0d want=1", frame_cnt);
    end
  endtask

  task automatic test_wrap;
    logic [34:0] f;
    int t5;
    do_reset;
    for (int k = 0; k < 256; k++) begin
      f = {3'($urandom), $urandom};
      scan(f, 6, 0, t5);
    end
    repeat (2) @(negedge CLK);
    checks += 2;
    if (frame_cnt !== 8'd0) begin
      errors++; $display("FAIL wrap_cnt got=%0d want=0", frame_cnt);
    end
    if (locked !== 1'b1) begin
      errors++; $display("FAIL wrap_locked got=%b want=1", locked);
    end
  endtask

  task automatic test_async_reset;
    logic [34:0] f;
    logic [34:0] f2;
    int t5;
    do_reset;
    f  = {7'h12, 7'h34, 7'h56, 7'h78 & 7'h7F, 7'h1A};
    f2 = {7'h0F, 7'h70, 7'h0F, 7'h70, 7'h0F};
    scan(f, 10, 0, t5);
    slot(5'b00001, 7'h01, 10);
    slot(5'b00010, 7'h02, 10);
    slot(5'b00100, 7'h03, 4);
    #2;
    RST = 1'b1;
    #1;
    checks += 4;
    if (frame !== 35'd0) begin
      errors++; $display("FAIL arst_frame got=%h want=0", frame);
    end
    if (locked !== 1'b0) begin
      errors++; $display("FAIL arst_locked got=%b want=0", locked);
    end
    if (frame_cnt !== 8'd0) begin
      errors++; $display("FAIL arst_cnt got=%0d want=0", frame_cnt);
    end
    if (frame_valid !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL arst_pulses got=%b%b want=00", frame_valid, error);
    end
    L = 5'd0;
    C = 7'd0;
    exp_cnt = 8'd0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    scan(f2, 10, 0, t5);
    repeat (2) @(negedge CLK);
    checks += 2;
    if (frame !== f2) begin
      errors++; $display("FAIL arst_frame2 got=%h want=%h", frame, f2);
    end
    if (frame_cnt !== 8'd1) begin
      errors++; $display("FAIL arst_cnt2 got=%0d want=1", frame_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_clean_frame;
    test_glitch;
    test_short_slot;
    test_skip_row;
    test_multi_blank;
    test_timeout;
    test_wrap;
    test_async_reset;
    do_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
